// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: sequencing controller for a combinational GRU cell.
// Accepts one sample X_t, presents X_t and h_{t-1} to the external cell,
// waits SETTLE_CYCLES edges, then captures h_t and offers it downstream.
// h_{t-1} is carried between samples of a sequence and cleared after the
// final sample, on clr, or on reset.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low. in_ready depends only on the FSM state, never on in_valid. out_valid
// does not depend on out_ready.
module gru_seq_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FRACT_WIDTH   = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_h,
  output logic                  out_last,
  output logic [CNT_W-1:0]      step_cnt,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Fixed-point format is carried by the data only; no arithmetic here.
  localparam int unused_fract = FRACT_WIDTH;

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] h_reg;
  logic                  last_reg;
  logic [3:0]            settle_cnt;

  // Cell operands come straight from registers so the cell sees clean inputs.
  assign cell_x    = x_reg;
  assign cell_h_in = h_reg;

  // Status derived from the state register only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Main controller: accept, settle countdown, capture, emit, flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_reg      <= '0;
      h_reg      <= '0;
      last_reg   <= 1'b0;
      settle_cnt <= '0;
      step_cnt   <= '0;
      out_h      <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (clr) begin
      // Flush wins over any handshake on the same edge.
      state     <= IDLE;
      x_reg     <= '0;
      h_reg     <= '0;
      step_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg      <= in_data;
            last_reg   <= in_last;
            settle_cnt <= SETTLE_INIT;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            h_reg     <= cell_h_out;
            out_h     <= cell_h_out;
            out_last  <= last_reg;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (out_last) begin
              // End of sequence: next sequence starts from a zero state.
              step_cnt <= '0;
              h_reg    <= '0;
            end else if (step_cnt != CNT_MAX) begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with a behavioural cell h_out = x + h.
// CNT_W is set to 2 so the step counter saturation is reachable.
`timescale 1ns/1ps
module tb_gru_seq_ctrl;

  localparam int DW = 8;
  localparam int CW = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [DW-1:0] cell_x;
  logic [DW-1:0] cell_h_in;
  logic [DW-1:0] cell_h_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_h;
  logic          out_last;
  logic [CW-1:0] step_cnt;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural GRU cell stand-in.
  assign cell_h_out = cell_x + cell_h_in;

  gru_seq_ctrl #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(5), .SETTLE_CYCLES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cell_x(cell_x), .cell_h_in(cell_h_in), .cell_h_out(cell_h_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h), .out_last(out_last),
    .step_cnt(step_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample, then wait out the settle window; returns in EMIT.
  task automatic feed(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    chk("pre_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    // Later changes on the input bus must not reach the cell.
    in_data  = DW'($urandom_range(0, 255));
    in_last  = 1'($urandom_range(0, 1));
    chk("acc_busy", busy, 1);
    chk("acc_in_ready", in_ready, 0);
    chk("acc_cell_x", cell_x, d);
    step();
    chk("settle_out_valid", out_valid, 0);
    step();
  endtask

  // Full sample with immediate acceptance downstream.
  task automatic run(input logic [DW-1:0] d, input logic l,
                     input logic [DW-1:0] exp_h, input logic [CW-1:0] exp_cnt,
                     input logic [DW-1:0] exp_hin);
    out_ready = 1'b1;
    feed(d, l);
    chk("emit_out_valid", out_valid, 1);
    chk("emit_out_h", out_h, exp_h);
    chk("emit_out_last", out_last, l);
    step();
    chk("post_out_valid", out_valid, 0);
    chk("post_step_cnt", step_cnt, exp_cnt);
    chk("post_cell_h_in", cell_h_in, exp_hin);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_h", out_h, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_cell_h_in", cell_h_in, 0);
    chk("rst_cell_x", cell_x, 0);
    step();
    step();
    rst_n = 1'b1;

    // Single step, accepted on the first edge after reset release
    run(8'h20, 1'b1, 8'h20, 2'd0, 8'h00);

    // Three-sample sequence
    run(8'h08, 1'b0, 8'h08, 2'd1, 8'h08);
    run(8'h08, 1'b0, 8'h10, 2'd2, 8'h10);
    run(8'h08, 1'b1, 8'h18, 2'd0, 8'h00);

    // Backpressure in EMIT
    out_ready = 1'b0;
    feed(8'h04, 1'b0);
    chk("bp_out_valid0", out_valid, 1);
    chk("bp_out_h0", out_h, 8'h04);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_h", out_h, 8'h04);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_out_valid", out_valid, 0);
    chk("bp_rel_step_cnt", step_cnt, 1);
    chk("bp_rel_cell_h_in", cell_h_in, 8'h04);

    // clr during SETTLE of the second sample
    in_valid = 1'b1;
    in_data  = 8'h04;
    in_last  = 1'b0;
    step();
    in_valid = 1'b0;
    chk("clr_pre_busy", busy, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_cell_h_in", cell_h_in, 0);
    chk("clr_cell_x", cell_x, 0);
    chk("clr_step_cnt", step_cnt, 0);
    step();
    step();
    chk("clr_no_emit", out_valid, 0);

    // clr coincident with in_valid in IDLE drops the sample
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc_busy", busy, 0);
    chk("clr_acc_cell_x", cell_x, 0);

    // Asynchronous reset while in EMIT
    out_ready = 1'b0;
    feed(8'h02, 1'b0);
    chk("rstemit_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_h", out_h, 0);
    chk("arst_cell_h_in", cell_h_in, 0);
    chk("arst_step_cnt", step_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    run(8'h08, 1'b1, 8'h08, 2'd0, 8'h00);

    // Step counter saturation with a 2-bit counter
    run(8'h01, 1'b0, 8'h01, 2'd1, 8'h01);
    run(8'h01, 1'b0, 8'h02, 2'd2, 8'h02);
    run(8'h01, 1'b0, 8'h03, 2'd3, 8'h03);
    run(8'h01, 1'b0, 8'h04, 2'd3, 8'h04);
    run(8'h01, 1'b0, 8'h05, 2'd3, 8'h05);
    run(8'h01, 1'b1, 8'h06, 2'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
